// File: rtl/reg_sniff_fifo_if.sv
// Byte-wide register bus between the reg_main USB host front end and a register slave.
interface reg_sniff_fifo_if;
    logic [5:0]  reg_address;
    logic [15:0] reg_bytecnt;
    logic        reg_read;
    logic        reg_write;
    logic        reg_addrvalid;
    logic [7:0]  write_data;
    logic [7:0]  read_data;

    modport master (
        output reg_address, reg_bytecnt, reg_read, reg_write, reg_addrvalid, write_data,
        input  read_data
    );

    modport slave (
        input  reg_address, reg_bytecnt, reg_read, reg_write, reg_addrvalid, write_data,
        output read_data
    );
endinterface

// File: rtl/reg_sniff_fifo.sv
// Capture-side sniff FIFO with a bytewise host register front end: pop/read port,
// fill count, high-water mark, thresholds and sticky underflow/overflow flags.
module reg_sniff_fifo #(
    parameter int         pDATA_WIDTH   = 18,
    parameter int         pDEPTH        = 512,
    parameter logic [5:0] pADDR_FIFO_RD = 6'd20,
    parameter logic [5:0] pADDR_STAT    = 6'd21,
    parameter logic [5:0] pADDR_COUNT   = 6'd22,
    parameter logic [5:0] pADDR_PEAK    = 6'd23,
    parameter logic [5:0] pADDR_THRESH  = 6'd24,
    parameter logic [5:0] pADDR_FLUSH   = 6'd25
) (
    input  logic                      cwusb_clk,
    input  logic                      reset_n,
    reg_sniff_fifo_if.slave           reg_bus,
    input  logic                      I_wr,
    input  logic [pDATA_WIDTH-1:0]    I_din,
    input  logic                      I_flush,
    output logic                      O_full,
    output logic                      O_empty,
    output logic [$clog2(pDEPTH):0]   O_count
);
    localparam int AW = $clog2(pDEPTH);
    localparam int CW = AW + 1;

    logic [pDATA_WIDTH-1:0] mem [pDEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count, peak, count_nxt;
    logic [pDATA_WIDTH-1:0] dout_r;
    logic                   underflow, overflow;
    logic [15:0]            empty_thresh, full_thresh;
    logic [7:0]             rdata_r;

    logic        host_rd, host_wr, wr_b0, full, empty, pop_req, flush_now, push, pop_ok;
    logic        clr_uf, clr_of, empty_thr, full_thr;
    logic [7:0]  stat_byte, reg_byte, fifo_byte;
    logic [31:0] reg_word;
    logic [63:0] dout_ext;

    assign host_rd   = reg_bus.reg_addrvalid & reg_bus.reg_read;
    assign host_wr   = reg_bus.reg_addrvalid & reg_bus.reg_write;
    assign wr_b0     = host_wr & (reg_bus.reg_bytecnt == 16'd0);
    assign full      = (count == CW'(pDEPTH));
    assign empty     = (count == '0);
    assign pop_req   = host_rd & (reg_bus.reg_address == pADDR_FIFO_RD) & (reg_bus.reg_bytecnt == 16'd0);
    assign flush_now = I_flush | (wr_b0 & (reg_bus.reg_address == pADDR_FLUSH) & reg_bus.write_data[0]);
    assign push      = I_wr & ~full & ~flush_now;
    assign pop_ok    = pop_req & ~empty;
    assign count_nxt = count + CW'(push) - CW'(pop_ok);
    assign clr_uf    = wr_b0 & (reg_bus.reg_address == pADDR_STAT) & reg_bus.write_data[1];
    assign clr_of    = wr_b0 & (reg_bus.reg_address == pADDR_STAT) & reg_bus.write_data[4];

    assign empty_thr = (16'(count) <= empty_thresh) & ~empty;
    assign full_thr  = (16'(count) >= full_thresh) & ~full;
    assign stat_byte = {2'b00, full_thr, overflow, full, empty_thr, underflow, empty};

    always_comb begin
        reg_word = '0;
        case (reg_bus.reg_address)
            pADDR_STAT:   reg_word = 32'(stat_byte);
            pADDR_COUNT:  reg_word = 32'(count);
            pADDR_PEAK:   reg_word = 32'(peak);
            pADDR_THRESH: reg_word = {full_thresh, empty_thresh};
            default:      reg_word = '0;
        endcase
    end

    // Zero-extended sources make bytes past each register's width read back as 0.
    assign reg_byte  = (reg_bus.reg_bytecnt < 16'd4) ?
                       8'(reg_word >> {reg_bus.reg_bytecnt[1:0], 3'b000}) : 8'h00;
    assign dout_ext  = 64'(dout_r);
    assign fifo_byte = (reg_bus.reg_bytecnt < 16'd8) ?
                       8'(dout_ext >> {reg_bus.reg_bytecnt[2:0], 3'b000}) : 8'h00;

    // FIFO read port is combinational off dout_r; every other register is registered.
    assign reg_bus.read_data = (reg_bus.reg_address == pADDR_FIFO_RD) ? fifo_byte : rdata_r;

    assign O_full  = full;
    assign O_empty = empty;
    assign O_count = count;

    always_ff @(posedge cwusb_clk) begin
        if (push) mem[wr_ptr] <= I_din;
    end

    always_ff @(posedge cwusb_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            peak         <= '0;
            dout_r       <= '0;
            underflow    <= 1'b0;
            overflow     <= 1'b0;
            rdata_r      <= 8'h00;
            empty_thresh <= 16'd1;
            full_thresh  <= 16'(pDEPTH - 1);
        end else begin
            rdata_r <= host_rd ? reg_byte : 8'h00;
            if (flush_now) begin
                // A pop landing on the flush still hands back the old head.
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                peak      <= '0;
                underflow <= 1'b0;
                overflow  <= 1'b0;
                dout_r    <= pop_ok ? mem[rd_ptr] : '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    dout_r <= mem[rd_ptr];
                end
                count     <= count_nxt;
                peak      <= (count_nxt > peak) ? count_nxt : peak;
                underflow <= (underflow & ~clr_uf) | (pop_req & empty);
                overflow  <= (overflow & ~clr_of) | (I_wr & full);
            end
            if (host_wr && reg_bus.reg_address == pADDR_THRESH) begin
                case (reg_bus.reg_bytecnt)
                    16'd0:   empty_thresh[7:0]  <= reg_bus.write_data;
                    16'd1:   empty_thresh[15:8] <= reg_bus.write_data;
                    16'd2:   full_thresh[7:0]   <= reg_bus.write_data;
                    16'd3:   full_thresh[15:8]  <= reg_bus.write_data;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/reg_sniff_fifo.md
Name: reg_sniff_fifo

Overview:
Parametrised, single-clock sniff FIFO with a built-in register-interface front end, sitting between the front-end capture path and the reg_main USB register bus.
- Stores pDATA_WIDTH-bit capture entries.
- Lets the host pop and read each entry bytewise through the FIFO read address.
- Exposes fill count, high-water mark, programmable thresholds and sticky error flags.
- Everything runs in the cwusb_clk domain, so no CDC is required.

Parameters:
pDATA_WIDTH, 18, entry width in bits (1..64).
pDEPTH, 512, entry count; power of 2, 4..4096.
pADDR_FIFO_RD, 6'd20, register address of FIFO read port.
pADDR_STAT, 6'd21, status/clear register address.
pADDR_COUNT, 6'd22, fill count (read-only).
pADDR_PEAK, 6'd23, high-water mark (read-only).
pADDR_THRESH, 6'd24, thresholds: bytes 0-1 empty threshold, bytes 2-3 full threshold.
pADDR_FLUSH, 6'd25, write bit0=1 to flush.

Ports:
cwusb_clk  in  1  sole clock.
reset_n  in  1  asynchronous, active-low reset.
reg_address  in  6  register address.
reg_bytecnt  in  16  byte index within register.
reg_read  in  1  read strobe.
reg_write  in  1  write strobe.
reg_addrvalid  in  1  address valid.
write_data  in  8  host write byte.
read_data  out  8  host read byte.
I_wr  in  1  push request.
I_din  in  pDATA_WIDTH  push data.
I_flush  in  1  flush pulse (e.g. on arm).
O_full  out  1  FIFO full.
O_empty  out  1  FIFO empty.
O_count  out  CW=log2(pDEPTH)+1  current fill.

Behaviour:
- Reset (reset_n low, asynchronous):
  - pointers, count, peak, stickies and dout_r all 0.
  - O_empty=1, O_full=0, read_data=0.
  - empty_thresh=1, full_thresh=pDEPTH-1.
- Push and pop conditions:
  - push = I_wr & ~full & ~flush_now.
  - pop = addrvalid & reg_read & (reg_address==pADDR_FIFO_RD) & (reg_bytecnt==0).
  - flush_now = I_flush | (host write to pADDR_FLUSH with write_data[0]=1).
- Pop on a non-empty FIFO: the head entry loads into dout_r on the same edge.
- FIFO read port output: read_data = byte reg_bytecnt of dout_r, combinational.
  - Data is therefore valid the cycle after reg_read.
  - Top byte is zero-padded.
  - Bytes at index >= ceil(pDATA_WIDTH/8) read 0.
- Pop on an empty FIFO: sets underflow sticky; pointers and dout_r are unchanged.
- I_wr while full: entry dropped; overflow sticky set.
- Full is evaluated before the same-cycle pop. Push+pop while full: push dropped, pop succeeds, count drops by 1.
- Push+pop while empty: push succeeds, pop is an underflow.
- Push+pop while neither empty nor full: count unchanged.
- Pointers are log2(pDEPTH) bits and wrap naturally. count = 0..pDEPTH. O_full = (count==pDEPTH), O_empty = (count==0).
- Peak register: peak <= max(peak, next count) every cycle. Cleared by flush.
- Flush completes in one cycle:
  - pointers, count, peak, both stickies and dout_r are cleared.
  - a same-cycle I_wr is dropped and does not set overflow.
  - a same-cycle pop returns the old head without an underflow.
- Status byte: bit0 empty, bit1 underflow sticky, bit2 empty_thr, bit3 full, bit4 overflow sticky, bit5 full_thr, bits7:6 0.
  - empty_thr = (count<=empty_thresh) & ~empty.
  - full_thr = (count>=full_thresh) & ~full.
  - Host write to pADDR_STAT: write-1-to-clear on bits 1 and 4.
  - If a set event and a clear land in the same cycle, set wins.
- Non-FIFO reads are registered: read_data is valid one cycle after addrvalid&reg_read and is 0 otherwise.
  - Bytes beyond a register's width read 0.
  - Unknown address reads 0.
- Host writes to bytes beyond a register's width are ignored. Writes to read-only registers are ignored.
- Thresholds are 16-bit little-endian.

Test Plan:
- Reset with pDEPTH=8: assert reset_n=0 mid-burst -> O_empty=1, O_count=0, status=8'h01, thresholds read 1 and 7.
- Push 0x2A5A5 then 0x15555 (18-bit); host reads bytecnt 0,1,2 -> A5,A5,02; next entry -> 55,55,01; O_count=0, peak=2.
- Fill to 8 then push 0x3 -> O_full=1, dropped, status bit4=1. Write 0x10 to STAT -> bit4=0. Same-cycle push+pop while full -> count=7.
- Pop while empty -> status bit1=1, dout_r unchanged. I_flush with I_wr high same cycle -> count=0, peak=0, bits1/4=0, entry not stored.
- Pointer wrap: 20 push/pop pairs interleaved with depth never >3 -> data order preserved, peak=3.
- Thresholds: write empty_thresh=2, full_thresh=6. Count 2 -> bit2=1. Count 6 -> bit5=1. Count 8 -> bit5=0, bit3=1.
